// File: rtl/ysyx_23060332_sram_if.sv
// ysyx_23060332_sram_if
//   Request/response channel pair between the LSU (master) and the SRAM
//   responder (slave).
//   req_valid/req_ready         request handshake
//   req_wen/addr/wdata/wmask    request payload (sampled only at acceptance)
//   resp_valid/resp_ready       response handshake
//   resp_rdata/resp_err         response payload
interface ysyx_23060332_sram_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_23060332_sram.sv
// ysyx_23060332_sram
//   Single-outstanding memory responder with programmable latency.
//   Holds DEPTH 64-bit words starting at byte address BASE; accepts one read
//   or byte-masked write and answers LATENCY cycles after acceptance.
//   clk  rising-edge clock
//   rst  synchronous active-high reset (store contents are not reset)
//   bus  slave side of ysyx_23060332_sram_if (request + response channels)
module ysyx_23060332_sram #(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_23060332_sram_if.slave bus
);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam bit          ONE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        wen_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;
    logic        resp_valid_q;
    logic [63:0] resp_rdata_q;
    logic        resp_err_q;

    logic [63:0] mem [DEPTH];

    logic             accept;
    logic             do_access;
    logic             acc_wen;
    logic [63:0]      acc_addr;
    logic [63:0]      acc_wdata;
    logic [7:0]       acc_wmask;
    logic [63:0]      off;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             unused_off_bits;

    assign accept = !rst && (state == IDLE) && bus.req_valid;

    // The access happens on the edge where the counter reaches zero, so it is
    // triggered while the counter still reads 1 (LATENCY-1 edges after accept).
    // With LATENCY == 1 it happens on the acceptance edge itself.
    assign do_access = (accept && ONE_CYCLE) ||
                       (!rst && (state == BUSY) && (cnt == 8'd1));

    // The single-cycle case accesses straight from the request inputs; every
    // other access uses the latched copy.
    always_comb begin
        acc_wen   = wen_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wmask = wmask_q;
        if (state == IDLE) begin
            acc_wen   = bus.req_wen;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_wmask = bus.req_wmask;
        end
    end

    assign off             = acc_addr - BASE;
    assign in_range        = (acc_addr >= BASE) && ({3'b000, off[63:3]} < 64'(DEPTH));
    assign idx             = off[IDX_W+2:3];
    assign unused_off_bits = ^off[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wen_q   <= bus.req_wen;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        wmask_q <= bus.req_wmask;
                        cnt     <= 8'(LATENCY - 1);
                        if (ONE_CYCLE) state <= RESP;
                        else           state <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) state <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (do_access) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= (in_range && !acc_wen) ? mem[idx] : '0;
                resp_err_q   <= !in_range;
            end
        end
    end

    // Store has no reset; contents come from the environment.
    always_ff @(posedge clk) begin
        if (do_access && acc_wen && in_range) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (acc_wmask[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = !rst && (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule
